n_bit_adder: RTL and testbench
==============================

N_BIT_ADDER -- requirements
Module: n_bit_adder

Interface
- REQ-001: Parameter WIDTH, default 8, operand and sum bit width; the block SHALL support any WIDTH >= 1.
- REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge only.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: en  input  1  result-register load enable, active-high.
- REQ-005: a  input  WIDTH  operand A, unsigned.
- REQ-006: b  input  WIDTH  operand B, unsigned.
- REQ-007: cin  input  1  carry-in.
- REQ-008: s  output  WIDTH  registered sum.
- REQ-009: c  output  1  registered carry-out.

Function
- REQ-010: The datapath SHALL be a ripple-carry chain of WIDTH one-bit full-adder cells.
  - Cell 0 carry-in SHALL be cin.
  - Cell i carry-in SHALL be the carry-out of cell i-1.
  - The carry-out of cell WIDTH-1 SHALL form the carry result.
- REQ-011: Each full-adder cell SHALL compute sum = x XOR y XOR ci and co = (x AND y) OR (ci AND (x XOR y)).
- REQ-012: The combinational result SHALL equal the low WIDTH+1 bits of a + b + cin.
  - Bit WIDTH SHALL be the carry.
  - No overflow beyond WIDTH+1 bits is possible.
- REQ-013: On a rising clk edge with rst=0 and en=1, s SHALL load the combinational sum and c SHALL load the carry.
- REQ-014: Latency SHALL be exactly one clock: a, b and cin sampled at edge N SHALL appear on s and c immediately after edge N.
- REQ-015: On a rising clk edge with rst=0 and en=0, s and c SHALL hold their previous values.
- REQ-016: s and c SHALL be driven only by the result register; no combinational path from a, b, cin or en to s or c is permitted.
- REQ-017: Wrap-around: a=2^WIDTH-1, b=0, cin=1 SHALL produce s=0 and c=1.
- REQ-018: Maximum case: a=b=2^WIDTH-1, cin=1 SHALL produce s=2^WIDTH-1 and c=1.
- REQ-019: Inputs changing between edges SHALL have no effect on s or c until the next enabled edge.
- REQ-020: There is no handshake; a new operation SHALL be accepted on every enabled edge, for a throughput of one result per cycle.

Reset
- REQ-021: While rst=1, s SHALL be 0 and c SHALL be 0, immediately and independent of clk and en.
- REQ-022: Reset asserted between clock edges (mid-operation) SHALL clear s and c without waiting for an edge.
- REQ-023: Reset SHALL take priority over en on any edge coincident with rst=1.
- REQ-024: After rst deasserts, the first rising edge with en=1 SHALL load a normal result.
- REQ-025: The register SHALL have no state other than s and c.

Verification (WIDTH=8)
- REQ-026: Reset: assert rst=1 with no clock edge -> s=0x00, c=0 immediately; hold rst=1 across an edge with a=0x12, b=0x34, en=1 -> s=0x00, c=0.
- REQ-027: Basic add: a=0x0F, b=0x01, cin=0, en=1, one edge -> s=0x10, c=0; a=0x12, b=0x34, cin=1 on the next edge -> s=0x47, c=0.
- REQ-028: Full ripple: a=0xFF, b=0x00, cin=1 -> s=0x00, c=1; a=0xFF, b=0xFF, cin=1 -> s=0xFF, c=1; a=0x80, b=0x80, cin=0 -> s=0x00, c=1.
- REQ-029: Enable hold: load s=0x10, then set en=0 and a=0xAA, b=0x55, cin=1 for 3 edges -> s=0x10, c=0 unchanged; set en=1, one edge -> s=0x00, c=1.
- REQ-030: Mid-stream reset: drive random a, b, cin every edge with a one-cycle rst pulse after 40 cycles -> s=0, c=0 during the pulse; the first edge after release gives the correct sum.
- REQ-031: Randomized check: at least 1000 random a, b, cin with en=1 -> each result matches {c,s} = a + b + cin one cycle later.
- REQ-032: Randomized parameters: repeat the randomized check at WIDTH=1 and WIDTH=16.

Source files
------------

// File: rtl/n_bit_adder.sv
// -----------------------------------------------------------------------------
// n_bit_adder
//   Registered WIDTH-bit unsigned adder built from a ripple-carry chain of
//   one-bit full-adder cells. The sum and carry-out are captured in a result
//   register on enabled rising edges. Between enabled edges the register holds
//   its value. The asynchronous reset clears the register immediately.
//
// Ports
//   clk  in   1      rising-edge clock
//   rst  in   1      asynchronous, active-high reset (clears s and c)
//   en   in   1      result-register load enable, active-high
//   a    in   WIDTH  operand A, unsigned
//   b    in   WIDTH  operand B, unsigned
//   cin  in   1      carry-in to cell 0
//   s    out  WIDTH  registered sum
//   c    out  1      registered carry-out of cell WIDTH-1
// -----------------------------------------------------------------------------
module n_bit_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  // One full-adder cell. The result is packed as {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    logic p;
    p = x ^ y;
    return {(x & y) | (ci & p), p ^ ci};
  endfunction

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH:0]   carry;     // carry[i] feeds cell i; carry[WIDTH] is the carry result
  logic [WIDTH-1:0] s_d, s_q;
  logic             c_d, c_q;

  // Ripple-carry chain: each cell takes the carry-out of the previous cell.
  always_comb begin
    sum_comb = '0;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      {carry[i+1], sum_comb[i]} = full_add(a[i], b[i], carry[i]);
    end
  end

  // Next-state selection: load the new result when enabled, otherwise hold.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    if (en) begin
      s_d = sum_comb;
      c_d = carry[WIDTH];
    end else begin
      s_d = s_q;
      c_d = c_q;
    end
  end

  // Result register. The asynchronous reset takes priority over the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      c_q <= 1'b0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  // Outputs come straight from the register, so there is no combinational path from the inputs.
  assign s = s_q;
  assign c = c_q;

endmodule

// File: tb/tb_n_bit_adder.sv
// -----------------------------------------------------------------------------
// tb_n_bit_adder
//   Self-checking bench for n_bit_adder at WIDTH = 8, 1 and 16. The three
//   instances share clk, rst and en. The expected {c,s} value is plain
//   integer arithmetic a + b + cin, taken from the operands presented at
//   each edge.
// -----------------------------------------------------------------------------
module tb_n_bit_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [7:0]  a8, b8, s8;
  logic        cin8, c8;
  logic [0:0]  a1, b1, s1;
  logic        cin1, c1;
  logic [15:0] a16, b16, s16;
  logic        cin16, c16;

  int n_checks = 0;
  int n_fail   = 0;

  n_bit_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8), .cin(cin8), .s(s8), .c(c8)
  );
  n_bit_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1), .cin(cin1), .s(s1), .c(c1)
  );
  n_bit_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .a(a16), .b(b16), .cin(cin16), .s(s16), .c(c16)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one WIDTH=8 operation, clock it, and compare {c,s} with the expected 9-bit value.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic [8:0] exp);
    a8 = a; b8 = b; cin8 = ci;
    tick();
    check_eq(tag, {23'd0, c8, s8}, {23'd0, exp});
  endtask

  task automatic randomize_all();
    a8    = 8'($urandom);
    b8    = 8'($urandom);
    cin8  = 1'($urandom);
    a1    = 1'($urandom);
    b1    = 1'($urandom);
    cin1  = 1'($urandom);
    a16   = 16'($urandom);
    b16   = 16'($urandom);
    cin16 = 1'($urandom);
  endtask

  // Reference model: expected {c,s} for the operands currently driven.
  int exp8, exp1, exp16;
  task automatic model_capture();
    exp8  = int'(a8)  + int'(b8)  + int'(cin8);
    exp1  = int'(a1)  + int'(b1)  + int'(cin1);
    exp16 = int'(a16) + int'(b16) + int'(cin16);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_w8"},  {23'd0, c8, s8},   32'(exp8));
    check_eq({tag, "_w1"},  {30'd0, c1, s1},   32'(exp1));
    check_eq({tag, "_w16"}, {15'd0, c16, s16}, 32'(exp16));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    a1 = 1'b0;  b1 = 1'b0;  cin1 = 1'b0;
    a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;

    // The reset clears the outputs before any clock edge arrives.
    #1;
    check_eq("rst_noedge", {23'd0, c8, s8}, 32'd0);
    // The reset holds across an enabled edge.
    a8 = 8'h12; b8 = 8'h34; en = 1'b1;
    tick();
    check_eq("rst_edge", {23'd0, c8, s8}, 32'd0);
    check_eq("rst_edge_w16", {15'd0, c16, s16}, 32'd0);
    rst = 1'b0;

    // Basic additions and full-ripple cases.
    op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 9'h010);
    op8("add_12_34", 8'h12, 8'h34, 1'b1, 9'h047);
    op8("wrap_ff_00", 8'hFF, 8'h00, 1'b1, 9'h100);
    op8("max_ff_ff", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    op8("add_80_80", 8'h80, 8'h80, 1'b0, 9'h100);

    // Enable hold: outputs stay unchanged while en=0 and the inputs change.
    op8("hold_load", 8'h0F, 8'h01, 1'b0, 9'h010);
    en = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_en0", {23'd0, c8, s8}, 32'h010);
    end
    en = 1'b1;
    tick();
    check_eq("hold_reload", {23'd0, c8, s8}, 32'h100);

    // Inputs changing between edges do not reach the outputs.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    #2;
    check_eq("between_edges", {23'd0, c8, s8}, 32'h100);
    tick();
    check_eq("between_edges_load", {23'd0, c8, s8}, 32'h002);

    // Mid-stream reset: random traffic for 40 cycles, then a one-cycle reset pulse.
    for (int i = 0; i < 40; i++) begin
      randomize_all();
      model_capture();
      tick();
      check_all("stream");
    end
    randomize_all();
    rst = 1'b1;
    #1;
    check_eq("midrst_async", {23'd0, c8, s8}, 32'd0);
    check_eq("midrst_async_w16", {15'd0, c16, s16}, 32'd0);
    tick();
    check_eq("midrst_edge", {23'd0, c8, s8}, 32'd0);
    rst = 1'b0;
    randomize_all();
    model_capture();
    tick();
    check_all("after_rst");

    // Randomized check at all three widths, with a new operation every cycle.
    for (int i = 0; i < 1200; i++) begin
      randomize_all();
      model_capture();
      tick();
      check_all("rnd");
    end

    // Boundary cases at WIDTH=1 and WIDTH=16.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1;
    tick();
    check_eq("max_w1",  {30'd0, c1, s1}, 32'h3);
    check_eq("wrap_w16", {15'd0, c16, s16}, 32'h10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
